// File: rtl/lsu_bus_bridge.sv
//------------------------------------------------------------------------------
// Module      : lsu_bus_bridge
// Description : Bridges pipeline load/store requests onto a simple
//               valid/ready request bus with a separate read-data return.
//               Handles lane byte enables, store-data replication, load
//               sign/zero extension, misalignment detection and bus timeout.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    input  logic        req_re_i,
    input  logic [3:0]  req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        bus_valid_o,
    input  logic        bus_ready_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_RDATA = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);
    localparam logic [1:0]  c_SZ_BYTE = 2'd0;
    localparam logic [1:0]  c_SZ_HALF = 2'd1;
    localparam logic [1:0]  c_SZ_WORD = 2'd2;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_is_load;
    logic [1:0]  r_offset;
    logic [2:0]  r_funct3;
    logic [31:0] r_load_data;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;

    logic        w_is_store;
    logic        w_is_req;
    logic [1:0]  w_size;
    logic        w_misaligned;
    logic        w_accept;
    logic [3:0]  w_mask;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_timeout;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;

    // Decode the incoming request: a store wins over a simultaneous load,
    // so access size comes from the store mask whenever any lane is written.
    always_comb begin
        w_is_store = (req_we_i != 4'b0000);
        w_is_req   = req_valid_i && (req_re_i || w_is_store);
        if (w_is_store) begin
            if (req_we_i[3])      w_size = c_SZ_WORD;
            else if (req_we_i[1]) w_size = c_SZ_HALF;
            else                  w_size = c_SZ_BYTE;
        end else begin
            case (req_funct3_i[1:0])
                2'b10:   w_size = c_SZ_WORD;
                2'b01:   w_size = c_SZ_HALF;
                default: w_size = c_SZ_BYTE;
            endcase
        end
        w_misaligned = ((w_size == c_SZ_HALF) && req_addr_i[0]) ||
                       ((w_size == c_SZ_WORD) && (req_addr_i[1:0] != 2'b00));
        w_accept     = (r_state == S_IDLE) && w_is_req && !w_misaligned;
    end

    // Build the lane-relative mask, shift it to absolute lanes and replicate
    // store data so the selected byte/half lands on every candidate lane.
    always_comb begin
        if (w_is_store) begin
            w_mask = req_we_i;
        end else begin
            case (w_size)
                c_SZ_WORD: w_mask = 4'b1111;
                c_SZ_HALF: w_mask = 4'b0011;
                default:   w_mask = 4'b0001;
            endcase
        end
        w_be = w_mask << req_addr_i[1:0];
        case (w_size)
            c_SZ_WORD: w_wdata = req_wdata_i;
            c_SZ_HALF: w_wdata = {2{req_wdata_i[15:0]}};
            default:   w_wdata = {4{req_wdata_i[7:0]}};
        endcase
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        w_byte = bus_rdata_i[{r_offset, 3'b000} +: 8];
        w_half = bus_rdata_i[{r_offset[1], 4'b0000} +: 16];
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_ext = {24'h000000, w_byte};
            3'b101:  w_load_ext = {16'h0000, w_half};
            default: w_load_ext = bus_rdata_i;
        endcase
    end

    // The wait counter hitting the limit aborts the transaction; this takes
    // priority over a late ready/rvalid arriving in the same cycle.
    assign w_timeout = ((r_state == S_ADDR) || (r_state == S_RDATA)) &&
                       (r_cnt == c_TIMEOUT);

    // Transaction FSM: latch the request on accept, wait for the address
    // handshake, then (loads only) wait for read data, then one DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 16'd0;
            r_is_load   <= 1'b0;
            r_offset    <= 2'b00;
            r_funct3    <= 3'b000;
            r_load_data <= 32'd0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_be    <= 4'b0000;
            r_bus_wdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= S_ADDR;
                        r_cnt       <= 16'd0;
                        r_is_load   <= !w_is_store;
                        r_offset    <= req_addr_i[1:0];
                        r_funct3    <= req_funct3_i;
                        r_bus_we    <= w_is_store;
                        r_bus_addr  <= {req_addr_i[31:2], 2'b00};
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_is_store ? w_wdata : 32'd0;
                    end
                end
                S_ADDR: begin
                    if (w_timeout) begin
                        r_state <= S_DONE;
                        if (r_is_load) r_load_data <= 32'd0;
                    end else if (bus_ready_i) begin
                        r_state <= r_is_load ? S_RDATA : S_DONE;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_RDATA: begin
                    if (w_timeout) begin
                        r_state     <= S_DONE;
                        r_load_data <= 32'd0;
                    end else if (bus_rvalid_i) begin
                        r_state     <= S_DONE;
                        r_load_data <= w_load_ext;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_o      = w_accept || (r_state == S_ADDR) || (r_state == S_RDATA);
    assign misalign_o   = (r_state == S_IDLE) && w_is_req && w_misaligned;
    assign bus_valid_o  = (r_state == S_ADDR) && !w_timeout;
    assign bus_err_o    = w_timeout;
    assign load_valid_o = (r_state == S_DONE) && r_is_load;
    assign load_data_o  = r_load_data;
    assign bus_we_o     = r_bus_we;
    assign bus_addr_o   = r_bus_addr;
    assign bus_be_o     = r_bus_be;
    assign bus_wdata_o  = r_bus_wdata;

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_bridge.sv
//------------------------------------------------------------------------------
// Module      : tb_lsu_bus_bridge
// Description : Directed self-checking bench for lsu_bus_bridge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsu_bus_bridge;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_re_i;
    logic [3:0]  req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [2:0]  req_funct3_i;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        misalign_o;
    logic        bus_err_o;
    logic        bus_valid_o;
    logic        bus_ready_i;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;
    int hs0;

    lsu_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_re_i     (req_re_i),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_funct3_i (req_funct3_i),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o),
        .bus_valid_o  (bus_valid_o),
        .bus_ready_i  (bus_ready_i),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count address-phase handshakes to detect duplicate issues.
    always @(posedge clk) begin
        if (rst_n && bus_valid_o && bus_ready_i) hs_cnt <= hs_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Store with immediate ready; request held through DONE like a stalled pipeline.
    task automatic do_store(input logic re, input logic [3:0] we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd);
        logic [31:0] exp_addr;
        exp_addr = addr;
        exp_addr[1:0] = 2'b00;
        req_valid_i = 1'b1; req_re_i = re; req_we_i = we; req_addr_i = addr;
        req_wdata_i = wdata; req_funct3_i = 3'b010; bus_ready_i = 1'b1;
        #1;
        check("st_idle_stall", stall_o, 1);
        check("st_idle_valid", bus_valid_o, 0);
        tick;
        check("st_addr_valid", bus_valid_o, 1);
        check("st_addr_we", bus_we_o, 1);
        check("st_addr_addr", bus_addr_o, exp_addr);
        check("st_addr_be", bus_be_o, exp_be);
        check("st_addr_wdata", bus_wdata_o, exp_wd);
        check("st_addr_stall", stall_o, 1);
        tick;
        check("st_done_stall", stall_o, 0);
        check("st_done_valid", bus_valid_o, 0);
        check("st_done_lvalid", load_valid_o, 0);
        tick;
        req_valid_i = 1'b0; req_we_i = 4'b0000; req_re_i = 1'b0;
        #1;
        check("st_idle2_stall", stall_o, 0);
        check("st_idle2_valid", bus_valid_o, 0);
    endtask

    // Load with ready immediate and rvalid one cycle later; stray rvalid in
    // IDLE/ADDR carries junk data that must be ignored.
    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_data);
        logic [31:0] exp_addr;
        exp_addr = addr;
        exp_addr[1:0] = 2'b00;
        req_valid_i = 1'b1; req_re_i = 1'b1; req_we_i = 4'b0000; req_addr_i = addr;
        req_funct3_i = f3; bus_ready_i = 1'b1;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
        #1;
        check("ld_idle_stall", stall_o, 1);
        tick;
        check("ld_addr_valid", bus_valid_o, 1);
        check("ld_addr_we", bus_we_o, 0);
        check("ld_addr_addr", bus_addr_o, exp_addr);
        check("ld_addr_be", bus_be_o, exp_be);
        tick;
        bus_rdata_i = rdata;
        #1;
        check("ld_rdata_valid", bus_valid_o, 0);
        check("ld_rdata_stall", stall_o, 1);
        check("ld_rdata_lvalid", load_valid_o, 0);
        tick;
        bus_rvalid_i = 1'b0;
        #1;
        check("ld_done_lvalid", load_valid_o, 1);
        check("ld_done_data", load_data_o, exp_data);
        check("ld_done_stall", stall_o, 0);
        tick;
        req_valid_i = 1'b0; req_re_i = 1'b0;
        #1;
        check("ld_idle_lvalid", load_valid_o, 0);
        check("ld_hold_data", load_data_o, exp_data);
    endtask

    task automatic do_misalign(input logic re, input logic [3:0] we, input logic [2:0] f3,
                               input logic [31:0] addr);
        req_valid_i = 1'b1; req_re_i = re; req_we_i = we; req_funct3_i = f3;
        req_addr_i = addr; req_wdata_i = 32'hFFFFFFFF; bus_ready_i = 1'b1;
        #1;
        check("mis_pulse", misalign_o, 1);
        check("mis_stall", stall_o, 0);
        check("mis_valid", bus_valid_o, 0);
        tick;
        req_valid_i = 1'b0; req_re_i = 1'b0; req_we_i = 4'b0000;
        #1;
        check("mis_clear", misalign_o, 0);
        check("mis_valid2", bus_valid_o, 0);
        check("mis_stall2", stall_o, 0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid_i = 1'b0; req_re_i = 1'b0; req_we_i = 4'b0000;
        req_addr_i = 32'd0; req_wdata_i = 32'd0; req_funct3_i = 3'b000;
        bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'd0;
        tick;
        tick;
        check("rst_stall", stall_o, 0);
        check("rst_valid", bus_valid_o, 0);
        check("rst_ldata", load_data_o, 0);
        check("rst_lvalid", load_valid_o, 0);
        check("rst_err", bus_err_o, 0);
        check("rst_mis", misalign_o, 0);
        check("rst_we", bus_we_o, 0);
        check("rst_addr", bus_addr_o, 0);
        check("rst_be", bus_be_o, 0);
        check("rst_wdata", bus_wdata_o, 0);
        rst_n = 1'b1;
        tick;

        // Stores: sb/sh/sw, plus store-priority with re also set.
        do_store(1'b0, 4'b0001, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
        do_store(1'b0, 4'b0011, 32'h0000_2002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
        do_store(1'b1, 4'b1111, 32'h0000_2004, 32'h1234_5678, 4'b1111, 32'h1234_5678);
        do_store(1'b1, 4'b0001, 32'h0000_2001, 32'h0000_0077, 4'b0010, 32'h7777_7777);

        // Loads: extension and lane selection.
        do_load(32'h0000_2002, 3'b001, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
        do_load(32'h0000_2002, 3'b101, 32'h8001_1234, 4'b1100, 32'h0000_8001);
        do_load(32'h0000_2003, 3'b000, 32'h8001_1234, 4'b1000, 32'hFFFF_FF80);
        do_load(32'h0000_2003, 3'b100, 32'h8001_1234, 4'b1000, 32'h0000_0080);
        do_load(32'h0000_2001, 3'b000, 32'h8001_1234, 4'b0010, 32'h0000_0012);
        do_load(32'h0000_2000, 3'b010, 32'h8001_1234, 4'b1111, 32'h8001_1234);
        do_load(32'h0000_2000, 3'b001, 32'h7FFF_8123, 4'b0011, 32'hFFFF_8123);

        // Misaligned accesses.
        do_misalign(1'b0, 4'b1111, 3'b010, 32'h0000_3001);
        do_misalign(1'b1, 4'b0000, 3'b001, 32'h0000_2001);
        do_misalign(1'b1, 4'b0000, 3'b010, 32'h0000_2002);
        do_misalign(1'b0, 4'b0011, 3'b000, 32'h0000_2003);

        // Back-to-back store then load, ready delayed 3 cycles each.
        hs0 = hs_cnt;
        req_valid_i = 1'b1; req_re_i = 1'b0; req_we_i = 4'b1111; req_addr_i = 32'h0000_5000;
        req_wdata_i = 32'h1122_3344; bus_ready_i = 1'b0;
        #1;
        check("b2b_st_stall", stall_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick;
            req_addr_i = 32'h0000_9F00; req_wdata_i = 32'hFFFF_0000;
            #1;
            check("b2b_st_wait_valid", bus_valid_o, 1);
            check("b2b_st_wait_addr", bus_addr_o, 32'h0000_5000);
            check("b2b_st_wait_be", bus_be_o, 4'b1111);
            check("b2b_st_wait_wdata", bus_wdata_o, 32'h1122_3344);
            check("b2b_st_wait_we", bus_we_o, 1);
        end
        tick;
        bus_ready_i = 1'b1; req_addr_i = 32'h0000_5000; req_wdata_i = 32'h1122_3344;
        #1;
        check("b2b_st_ready_valid", bus_valid_o, 1);
        tick;
        bus_ready_i = 1'b0;
        #1;
        check("b2b_st_done_stall", stall_o, 0);
        check("b2b_st_done_valid", bus_valid_o, 0);
        tick;
        req_re_i = 1'b1; req_we_i = 4'b0000; req_addr_i = 32'h0000_6000; req_funct3_i = 3'b010;
        #1;
        check("b2b_ld_idle_valid", bus_valid_o, 0);
        check("b2b_ld_idle_stall", stall_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("b2b_ld_wait_valid", bus_valid_o, 1);
            check("b2b_ld_wait_we", bus_we_o, 0);
            check("b2b_ld_wait_addr", bus_addr_o, 32'h0000_6000);
            check("b2b_ld_wait_be", bus_be_o, 4'b1111);
        end
        tick;
        bus_ready_i = 1'b1;
        #1;
        check("b2b_ld_ready_valid", bus_valid_o, 1);
        tick;
        bus_ready_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
        #1;
        check("b2b_ld_rdata_stall", stall_o, 1);
        tick;
        bus_rvalid_i = 1'b0;
        #1;
        check("b2b_ld_done_lvalid", load_valid_o, 1);
        check("b2b_ld_done_data", load_data_o, 32'hCAFE_F00D);
        tick;
        req_valid_i = 1'b0; req_re_i = 1'b0;
        #1;
        check("b2b_handshakes", hs_cnt - hs0, 2);
        check("b2b_end_stall", stall_o, 0);

        // Timeout on a load with ready held low.
        req_valid_i = 1'b1; req_re_i = 1'b1; req_we_i = 4'b0000; req_addr_i = 32'h0000_4000;
        req_funct3_i = 3'b010; bus_ready_i = 1'b0;
        #1;
        check("to_idle_stall", stall_o, 1);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("to_wait_valid", bus_valid_o, 1);
            check("to_wait_err", bus_err_o, 0);
        end
        tick;
        check("to_err_pulse", bus_err_o, 1);
        check("to_err_valid", bus_valid_o, 0);
        tick;
        check("to_done_err", bus_err_o, 0);
        check("to_done_lvalid", load_valid_o, 1);
        check("to_done_data", load_data_o, 0);
        tick;
        req_valid_i = 1'b0; req_re_i = 1'b0;
        #1;
        check("to_idle_stall2", stall_o, 0);
        check("to_idle_lvalid", load_valid_o, 0);
        check("to_idle_valid", bus_valid_o, 0);

        // Give load_data a nonzero value, then reset during RDATA.
        do_load(32'h0000_2000, 3'b010, 32'h1357_9BDF, 4'b1111, 32'h1357_9BDF);
        req_valid_i = 1'b1; req_re_i = 1'b1; req_addr_i = 32'h0000_7000;
        req_funct3_i = 3'b010; bus_ready_i = 1'b1;
        #1;
        tick;
        check("rm_addr_valid", bus_valid_o, 1);
        tick;
        bus_ready_i = 1'b0;
        #1;
        check("rm_rdata_stall", stall_o, 1);
        rst_n = 1'b0; req_valid_i = 1'b0; req_re_i = 1'b0;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h5555_5555;
        tick;
        check("rm_valid", bus_valid_o, 0);
        check("rm_stall", stall_o, 0);
        check("rm_ldata", load_data_o, 0);
        check("rm_lvalid", load_valid_o, 0);
        check("rm_err", bus_err_o, 0);
        rst_n = 1'b1; bus_rvalid_i = 1'b0;
        tick;
        check("rm_lvalid2", load_valid_o, 0);
        check("rm_ldata2", load_data_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu_bus_bridge.md
LSU_BUS_BRIDGE -- requirements
Module: lsu_bus_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning bus wait cycles allowed before abort (legal range 1..65535).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  pipeline memory request present.
- req_re_i  in  1  load request.
- req_we_i  in  4  lane-relative store mask: 0001 sb, 0011 sh, 1111 sw, 0000 no store.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, LSB-aligned.
- req_funct3_i  in  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- stall_o  out  1  pipeline hold (drives pc/if_id enables low).
- load_data_o  out  32  extended load result.
- load_valid_o  out  1  one-cycle load completion pulse.
- misalign_o  out  1  one-cycle misaligned-access pulse.
- bus_err_o  out  1  one-cycle timeout pulse.
- bus_valid_o  out  1  bus request valid.
- bus_ready_i  in  1  bus accepts request.
- bus_we_o  out  1  1 store, 0 load.
- bus_addr_o  out  32  word address ({addr[31:2],2'b00}).
- bus_be_o  out  4  absolute byte enables.
- bus_wdata_o  out  32  lane-replicated store data.
- bus_rvalid_i  in  1  read data valid.
- bus_rdata_i  in  32  read data word.

Function
REQ-003 SHALL implement FSM IDLE, ADDR, RDATA, DONE.
REQ-004 IDLE: request accepted when req_valid_i=1 and (req_re_i=1 or req_we_i!=0) and aligned; latch addr/wdata/we/funct3; go ADDR.
REQ-005 Store takes priority when req_re_i=1 and req_we_i!=0 together; load ignored.
REQ-006 Misaligned: sh/lh/lhu with addr[0]=1; sw/lw with addr[1:0]!=0. SHALL pulse misalign_o for the IDLE cycle, issue no bus request, keep stall_o=0, stay IDLE.
REQ-007 stall_o SHALL be 1 combinationally in IDLE on an accepted request, 1 in ADDR and RDATA, 0 in DONE and otherwise.
REQ-008 ADDR: bus_valid_o=1; bus_we_o, bus_addr_o, bus_be_o and bus_wdata_o SHALL be held stable until bus_ready_i=1. On ready: store -> DONE, load -> RDATA.
REQ-009 bus_be_o SHALL be latched mask << addr[1:0]; loads SHALL use the same shifted mask derived from funct3 (lb 0001, lh 0011, lw 1111).
REQ-010 bus_wdata_o: sb {4{wdata[7:0]}}, sh {2{wdata[15:0]}}, sw wdata.
REQ-011 RDATA: bus_valid_o=0; wait for bus_rvalid_i; bus_rvalid_i in any other state SHALL be ignored.
REQ-012 Load extraction: byte at rdata[8*addr[1:0]+:8], half at rdata[16*addr[1]+:16]; lb/lh sign-extend; lbu/lhu zero-extend; lw unchanged. Register into load_data_o on rvalid; go DONE.
REQ-013 DONE: one cycle; load_valid_o=1 if the transaction was a load; req_valid_i ignored; -> IDLE.
REQ-014 load_data_o SHALL hold its value until the next load completes or times out.
REQ-015 Latency at zero wait states: store 3 cycles (IDLE, ADDR, DONE); load 4 cycles (IDLE, ADDR, RDATA, DONE).
REQ-016 Timeout counter: 16-bit, cleared on entry to ADDR and to RDATA, increments each cycle spent waiting there. When it reaches TIMEOUT_CYCLES: pulse bus_err_o, drop bus_valid_o, for loads set load_data_o=0 and pulse load_valid_o in DONE, then go DONE.

Reset
REQ-017 When rst_n=0 at a clock edge, SHALL go to IDLE and clear the counter, latched request, and load_data_o; all outputs 0 the following cycle.
REQ-018 Reset mid-transaction (ADDR/RDATA) SHALL abandon the transaction without pulsing load_valid_o or bus_err_o.

Verification
REQ-019 sb addr=0x1003 wdata=0xA5, ready immediate -> bus_addr=0x1000, be=1000, wdata=0xA5A5A5A5, stall 1,1,0.
REQ-020 lh addr=0x2002, rdata=0x8001_1234, rvalid 1 cycle after ready -> load_data_o=0xFFFF8001, load_valid_o pulses on cycle 4; lhu -> 0x00008001.
REQ-021 sw addr=0x3001 -> misalign_o pulses 1 cycle, bus_valid_o stays 0, stall_o stays 0.
REQ-022 lw, bus_ready_i held 0, TIMEOUT_CYCLES=4 -> bus_err_o pulse after 4 ADDR wait cycles, load_data_o=0, FSM back in IDLE 2 cycles later.
REQ-023 Back-to-back store then load with ready delayed 3 cycles -> bus signals stable during wait; second request issued only after DONE; no duplicate issue.
REQ-024 rst_n=0 during RDATA -> next cycle bus_valid_o=0, stall_o=0, load_data_o=0, no load_valid_o.
